// File: rtl/dmem_arbiter_if.sv
// Bus bundle for dmem_arbiter: CPU port, DMA port and memory side.
// cpu_err exists only when DMEM_MISALIGN_TRAP_EN is defined.
interface dmem_arbiter_if #(
   parameter int ADDR_W = 32,
   parameter int DATA_W = 32
);
   logic              cpu_req;
   logic              cpu_we;
   logic [1:0]        cpu_size;
   logic [ADDR_W-1:0] cpu_addr;
   logic [DATA_W-1:0] cpu_wdata;
   logic [DATA_W-1:0] cpu_rdata;
   logic              cpu_ack;
   logic              cpu_stall;
`ifdef DMEM_MISALIGN_TRAP_EN
   logic              cpu_err;
`endif
   logic              dma_req;
   logic              dma_we;
   logic [ADDR_W-1:0] dma_addr;
   logic [DATA_W-1:0] dma_wdata;
   logic [DATA_W-1:0] dma_rdata;
   logic              dma_ack;
   logic              mem_we;
   logic [ADDR_W-1:0] mem_addr;
   logic [DATA_W-1:0] mem_wd;
   logic [DATA_W-1:0] mem_rd;

   modport slave (
      input  cpu_req, cpu_we, cpu_size, cpu_addr, cpu_wdata,
      output cpu_rdata, cpu_ack, cpu_stall,
      input  dma_req, dma_we, dma_addr, dma_wdata,
      output dma_rdata, dma_ack,
      output mem_we, mem_addr, mem_wd,
      input  mem_rd
`ifdef DMEM_MISALIGN_TRAP_EN
      , output cpu_err
`endif
   );

   modport master (
      output cpu_req, cpu_we, cpu_size, cpu_addr, cpu_wdata,
      input  cpu_rdata, cpu_ack, cpu_stall,
      output dma_req, dma_we, dma_addr, dma_wdata,
      input  dma_rdata, dma_ack,
      input  mem_we, mem_addr, mem_wd,
      output mem_rd
`ifdef DMEM_MISALIGN_TRAP_EN
      , input cpu_err
`endif
   );
endinterface

// File: rtl/dmem_arbiter.sv
// Round-robin CPU/DMA data memory arbiter with RMW for sub-word stores.
// Optional DMEM_MISALIGN_TRAP_EN: misaligned CPU accesses ack with cpu_err.
module dmem_arbiter #(
   parameter int ADDR_W = 32,
   parameter int DATA_W = 32
) (
   input logic          clk,
   input logic          rst,
   dmem_arbiter_if.slave bus
);
   typedef enum logic [2:0] {
      IDLE,
      CPU_ACC,
      CPU_RMW_RD,
      CPU_RMW_WR,
      DMA_ACC
   } state_t;

   state_t            state;
   logic              last_dma;
   logic              we_q;
   logic [1:0]        size_q;
   logic [1:0]        lane_q;
   logic [15:0]       wd_q;
   logic              mem_we_q;
   logic [ADDR_W-1:0] mem_addr_q;
   logic [DATA_W-1:0] mem_wd_q;
   logic              cpu_ack_q;
   logic              dma_ack_q;
   logic [DATA_W-1:0] cpu_rd_q;
   logic [DATA_W-1:0] dma_rd_q;
   logic [DATA_W-1:0] merged;
   logic              cpu_grant;
   logic              dma_grant;
   logic              narrow_st;
   logic              misalign;
   logic              unused_dma_lsb;

   assign unused_dma_lsb = &{1'b0, bus.dma_addr[1:0]};

   // On a tie the port that did not win last time gets the grant.
   assign cpu_grant = bus.cpu_req & (~bus.dma_req | last_dma);
   assign dma_grant = bus.dma_req & ~cpu_grant;
   assign narrow_st = bus.cpu_we & ~bus.cpu_size[1];

`ifdef DMEM_MISALIGN_TRAP_EN
   logic err_q;
   assign misalign = ((bus.cpu_size == 2'b01) & bus.cpu_addr[0]) |
                     (bus.cpu_size[1] & (|bus.cpu_addr[1:0]));
   assign bus.cpu_err = err_q;
`else
   assign misalign = 1'b0;
`endif

   always_comb begin
      merged = bus.mem_rd;
      unique case (1'b1)
         size_q == 2'b00: merged[{lane_q, 3'b000} +: 8] = wd_q[7:0];
         size_q == 2'b01: merged[{lane_q[1], 4'b0000} +: 16] = wd_q;
         default: ;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state      <= IDLE;
         last_dma   <= 1'b1;
         we_q       <= 1'b0;
         size_q     <= 2'b00;
         lane_q     <= 2'b00;
         wd_q       <= '0;
         mem_we_q   <= 1'b0;
         mem_addr_q <= '0;
         mem_wd_q   <= '0;
         cpu_ack_q  <= 1'b0;
         dma_ack_q  <= 1'b0;
         cpu_rd_q   <= '0;
         dma_rd_q   <= '0;
`ifdef DMEM_MISALIGN_TRAP_EN
         err_q      <= 1'b0;
`endif
      end else begin
         mem_we_q  <= 1'b0;
         cpu_ack_q <= 1'b0;
         dma_ack_q <= 1'b0;
`ifdef DMEM_MISALIGN_TRAP_EN
         err_q     <= 1'b0;
`endif
         unique case (state)
            IDLE: begin
               if (cpu_grant) begin
                  last_dma   <= 1'b0;
                  we_q       <= bus.cpu_we;
                  size_q     <= bus.cpu_size;
                  lane_q     <= bus.cpu_addr[1:0];
                  wd_q       <= bus.cpu_wdata[15:0];
                  mem_addr_q <= {bus.cpu_addr[ADDR_W-1:2], 2'b00};
                  if (misalign) begin
                     state     <= CPU_ACC;
                     cpu_ack_q <= 1'b1;
`ifdef DMEM_MISALIGN_TRAP_EN
                     err_q     <= 1'b1;
`endif
                  end else if (narrow_st) begin
                     state <= CPU_RMW_RD;
                  end else begin
                     state     <= CPU_ACC;
                     mem_we_q  <= bus.cpu_we;
                     mem_wd_q  <= bus.cpu_wdata;
                     cpu_ack_q <= 1'b1;
                  end
               end else if (dma_grant) begin
                  last_dma   <= 1'b1;
                  we_q       <= bus.dma_we;
                  state      <= DMA_ACC;
                  mem_addr_q <= {bus.dma_addr[ADDR_W-1:2], 2'b00};
                  mem_we_q   <= bus.dma_we;
                  mem_wd_q   <= bus.dma_wdata;
                  dma_ack_q  <= 1'b1;
               end
            end
            CPU_ACC: begin
               if (!we_q) cpu_rd_q <= bus.mem_rd;
               state <= IDLE;
            end
            DMA_ACC: begin
               if (!we_q) dma_rd_q <= bus.mem_rd;
               state <= IDLE;
            end
            // Read word is merged straight into the write-data register.
            CPU_RMW_RD: begin
               mem_we_q  <= 1'b1;
               mem_wd_q  <= merged;
               cpu_ack_q <= 1'b1;
               state     <= CPU_RMW_WR;
            end
            CPU_RMW_WR: state <= IDLE;
            default:    state <= IDLE;
         endcase
      end
   end

   assign bus.mem_we    = mem_we_q;
   assign bus.mem_addr  = mem_addr_q;
   assign bus.mem_wd    = mem_wd_q;
   assign bus.cpu_ack   = cpu_ack_q;
   assign bus.dma_ack   = dma_ack_q;
   assign bus.cpu_stall = bus.cpu_req & ~cpu_ack_q;
   assign bus.cpu_rdata = (state == CPU_ACC) ? bus.mem_rd : cpu_rd_q;
   assign bus.dma_rdata = (state == DMA_ACC) ? bus.mem_rd : dma_rd_q;
endmodule

// File: tb/tb_dmem_arbiter.sv
// Scoreboard bench for dmem_arbiter with a word-addressed memory model.
// Stimulus queues expected writes/acks; a negedge monitor checks them.
module tb_dmem_arbiter;
   logic clk;
   logic rst;
   logic mem_init;
   int   tests;
   int   failed;
   int   rst_req;
   int   rst_seen;
   bit   done;
   bit   mon_done;

   typedef struct {
      logic        chk_rd;
      logic [31:0] rd;
      logic        err;
      int          stall;
   } cexp_t;
   typedef struct {
      logic        chk_rd;
      logic [31:0] rd;
   } dexp_t;
   typedef struct {
      logic [31:0] a;
      logic [31:0] d;
   } wexp_t;

   cexp_t cq[$];
   dexp_t dq[$];
   wexp_t wq[$];
   bit    oq[$];

   logic [31:0] mem [64];

   dmem_arbiter_if #(.ADDR_W(32), .DATA_W(32)) bus ();

   dmem_arbiter #(.ADDR_W(32), .DATA_W(32)) u_dut (
      .clk(clk),
      .rst(rst),
      .bus(bus)
   );

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   always @(posedge clk) begin
      if (mem_init) begin
         for (int i = 0; i < 64; i++) mem[i] <= 32'h0;
         mem[12] <= 32'h55667788;
      end else if (bus.mem_we) begin
         mem[bus.mem_addr[7:2]] <= bus.mem_wd;
      end
   end

   assign bus.mem_rd = mem[bus.mem_addr[7:2]];

   function automatic void chk(string nm, logic [31:0] act,
                               logic [31:0] exp);
      tests++;
      if (act !== exp) begin
         failed++;
         $display("FAIL %s: got %h expected %h", nm, act, exp);
      end
   endfunction

   // Monitor: the only process that compares and steps the counters.
   initial begin
      int    st;
      cexp_t ce;
      dexp_t de;
      wexp_t we;
      bit    who;
      st = 0;
      forever begin
         @(negedge clk);
         if (bus.mem_we === 1'b1) begin
            if (wq.size() == 0) chk("unexpected_write", 32'd1, 32'd0);
            else begin
               we = wq.pop_front();
               chk("mem_addr", bus.mem_addr, we.a);
               chk("mem_wd", bus.mem_wd, we.d);
            end
         end
         if (bus.cpu_ack === 1'b1 || bus.dma_ack === 1'b1) begin
            chk("ack_overlap", {31'b0, bus.cpu_ack & bus.dma_ack}, 32'd0);
            who = bus.dma_ack;
            if (oq.size() == 0) chk("unexpected_ack", 32'd1, 32'd0);
            else chk("grant_order", {31'b0, who}, {31'b0, oq.pop_front()});
         end
         if (bus.cpu_ack === 1'b1) begin
            if (cq.size() == 0) chk("cpu_ack_unexpected", 32'd1, 32'd0);
            else begin
               ce = cq.pop_front();
               if (ce.chk_rd) chk("cpu_rdata", bus.cpu_rdata, ce.rd);
               chk("cpu_stall_cycles", st, ce.stall);
`ifdef DMEM_MISALIGN_TRAP_EN
               chk("cpu_err", {31'b0, bus.cpu_err}, {31'b0, ce.err});
`endif
            end
            st = 0;
         end else if (bus.cpu_stall === 1'b1) begin
            st++;
         end else begin
            st = 0;
         end
         if (bus.dma_ack === 1'b1) begin
            if (dq.size() == 0) chk("dma_ack_unexpected", 32'd1, 32'd0);
            else begin
               de = dq.pop_front();
               if (de.chk_rd) chk("dma_rdata", bus.dma_rdata, de.rd);
            end
         end
         if (rst_req != rst_seen) begin
            rst_seen = rst_req;
            chk("rst_mem_we", {31'b0, bus.mem_we}, 32'd0);
            chk("rst_cpu_ack", {31'b0, bus.cpu_ack}, 32'd0);
            chk("rst_dma_ack", {31'b0, bus.dma_ack}, 32'd0);
            chk("rst_mem_addr", bus.mem_addr, 32'd0);
            chk("rst_mem_wd", bus.mem_wd, 32'd0);
            chk("rst_cpu_rdata", bus.cpu_rdata, 32'd0);
            chk("rst_dma_rdata", bus.dma_rdata, 32'd0);
         end
         if (done && !mon_done) begin
            chk("left_cpu_exp", cq.size(), 32'd0);
            chk("left_dma_exp", dq.size(), 32'd0);
            chk("left_writes", wq.size(), 32'd0);
            chk("mem_0x30_kept", mem[12], 32'h55667788);
            mon_done = 1'b1;
         end
      end
   end

   task automatic cpu_op(input logic we, input logic [1:0] sz,
                         input logic [31:0] a, input logic [31:0] wd,
                         input logic wr, input logic [31:0] ewa,
                         input logic [31:0] ewd, input logic [31:0] erd,
                         input int estall, input logic eerr,
                         input logic drop);
      int n;
      if (wr) wq.push_back('{a: ewa, d: ewd});
      cq.push_back('{chk_rd: !we, rd: erd, err: eerr, stall: estall});
      oq.push_back(1'b0);
      @(posedge clk); #1;
      bus.cpu_req   = 1'b1;
      bus.cpu_we    = we;
      bus.cpu_size  = sz;
      bus.cpu_addr  = a;
      bus.cpu_wdata = wd;
      @(posedge clk); #1;
      bus.cpu_addr  = a ^ 32'h4;
      bus.cpu_wdata = ~wd;
      bus.cpu_size  = ~sz;
      bus.cpu_we    = ~we;
      if (drop) bus.cpu_req = 1'b0;
      n = 0;
      do begin
         @(negedge clk);
         n++;
      end while (bus.cpu_ack !== 1'b1 && n < 10);
      if (bus.cpu_ack !== 1'b1) begin
         $display("FAIL cpu_ack_timeout: got no ack expected ack");
         $fatal(1, "cpu ack timeout");
      end
      @(posedge clk); #1;
      bus.cpu_req = 1'b0;
   endtask

   task automatic dma_op(input logic we, input logic [31:0] a,
                         input logic [31:0] wd, input logic [31:0] ewa,
                         input logic [31:0] erd);
      int n;
      if (we) wq.push_back('{a: ewa, d: wd});
      dq.push_back('{chk_rd: !we, rd: erd});
      oq.push_back(1'b1);
      @(posedge clk); #1;
      bus.dma_req   = 1'b1;
      bus.dma_we    = we;
      bus.dma_addr  = a;
      bus.dma_wdata = wd;
      @(posedge clk); #1;
      bus.dma_addr  = a ^ 32'h4;
      bus.dma_wdata = ~wd;
      bus.dma_we    = ~we;
      n = 0;
      do begin
         @(negedge clk);
         n++;
      end while (bus.dma_ack !== 1'b1 && n < 10);
      if (bus.dma_ack !== 1'b1) begin
         $display("FAIL dma_ack_timeout: got no ack expected ack");
         $fatal(1, "dma ack timeout");
      end
      @(posedge clk); #1;
      bus.dma_req = 1'b0;
   endtask

   initial begin
      int n;
      int k;
      tests = 0; failed = 0; rst_req = 0; rst_seen = 0;
      done = 1'b0; mon_done = 1'b0;
      rst = 1'b1; mem_init = 1'b1;
      bus.cpu_req = 1'b0; bus.cpu_we = 1'b0; bus.cpu_size = 2'b10;
      bus.cpu_addr = '0; bus.cpu_wdata = '0;
      bus.dma_req = 1'b0; bus.dma_we = 1'b0;
      bus.dma_addr = '0; bus.dma_wdata = '0;
      repeat (2) @(posedge clk);
      #1 rst = 1'b0; mem_init = 1'b0;
      rst_req++;

      cpu_op(1, 2'b10, 32'h1C, 32'hDEADBEEF, 1, 32'h1C, 32'hDEADBEEF, 0, 1, 0, 0);
      cpu_op(0, 2'b10, 32'h1C, 32'h0, 0, 0, 0, 32'hDEADBEEF, 1, 0, 0);
      dma_op(1, 32'h20, 32'h11223344, 32'h20, 0);
      cpu_op(1, 2'b00, 32'h22, 32'h000000AA, 1, 32'h20, 32'h11AA3344, 0, 2, 0, 0);
      dma_op(1, 32'h20, 32'h11223344, 32'h20, 0);
      cpu_op(1, 2'b01, 32'h22, 32'h0000BEEF, 1, 32'h20, 32'hBEEF3344, 0, 2, 0, 0);
      cpu_op(1, 2'b00, 32'h23, 32'h0000005A, 1, 32'h20, 32'h5AEF3344, 0, 2, 0, 0);
      cpu_op(1, 2'b00, 32'h20, 32'hFFFFFF77, 1, 32'h20, 32'h5AEF3377, 0, 2, 0, 0);
      cpu_op(1, 2'b01, 32'h20, 32'hABCD1234, 1, 32'h20, 32'h5AEF1234, 0, 2, 0, 0);
      cpu_op(0, 2'b10, 32'h20, 32'h0, 0, 0, 0, 32'h5AEF1234, 1, 0, 0);
      cpu_op(0, 2'b00, 32'h23, 32'h0, 0, 0, 0, 32'h5AEF1234, 1, 0, 0);
      dma_op(1, 32'h43, 32'hCAFEF00D, 32'h40, 0);
      dma_op(0, 32'h40, 32'h0, 0, 32'hCAFEF00D);

      // Byte store aborted by reset while reading for the merge.
      @(posedge clk); #1;
      bus.cpu_req = 1'b1; bus.cpu_we = 1'b1; bus.cpu_size = 2'b00;
      bus.cpu_addr = 32'h31; bus.cpu_wdata = 32'h000000EE;
      @(posedge clk); #1;
      rst = 1'b1; bus.cpu_req = 1'b0;
      @(posedge clk); #1;
      rst = 1'b0;
      rst_req++;
      repeat (3) @(posedge clk);

      // Both ports held: grants must alternate, CPU first after reset.
      cq.push_back('{chk_rd: 1, rd: 32'hDEADBEEF, err: 0, stall: 1});
      dq.push_back('{chk_rd: 1, rd: 32'hCAFEF00D});
      cq.push_back('{chk_rd: 1, rd: 32'hDEADBEEF, err: 0, stall: 3});
      dq.push_back('{chk_rd: 1, rd: 32'hCAFEF00D});
      oq.push_back(1'b0); oq.push_back(1'b1);
      oq.push_back(1'b0); oq.push_back(1'b1);
      #1;
      bus.cpu_req = 1'b1; bus.cpu_we = 1'b0; bus.cpu_size = 2'b10;
      bus.cpu_addr = 32'h1C;
      bus.dma_req = 1'b1; bus.dma_we = 1'b0; bus.dma_addr = 32'h40;
      n = 0; k = 0;
      while (k < 4 && n < 40) begin
         @(negedge clk);
         n++;
         if (bus.cpu_ack === 1'b1 || bus.dma_ack === 1'b1) k++;
      end
      if (k < 4) begin
         $display("FAIL alternate_timeout: got %0d acks expected 4", k);
         $fatal(1, "alternation timeout");
      end
      @(posedge clk); #1;
      bus.cpu_req = 1'b0; bus.dma_req = 1'b0;

      cpu_op(0, 2'b10, 32'h30, 32'h0, 0, 0, 0, 32'h55667788, 1, 0, 0);
`ifdef DMEM_MISALIGN_TRAP_EN
      cpu_op(1, 2'b10, 32'h21, 32'h99887766, 0, 0, 0, 0, 1, 1, 0);
`else
      cpu_op(1, 2'b10, 32'h21, 32'h99887766, 1, 32'h20, 32'h99887766, 0, 1, 0, 0);
`endif
      cpu_op(0, 2'b10, 32'h1C, 32'h0, 0, 0, 0, 32'hDEADBEEF, 1, 0, 1);

      repeat (3) @(posedge clk);
      done = 1'b1;
      n = 0;
      while (!mon_done && n < 10) begin
         @(posedge clk);
         n++;
      end
      if (!mon_done) begin
         $display("FAIL monitor_done: got 0 expected 1");
         $fatal(1, "monitor stalled");
      end
      $display("[TB] %0d tests run, %0d failed", tests, failed);
      $finish;
   end
endmodule
